// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the L2 CPU-side port between the L1 I- and D-caches.
// The winning request is latched and held on the L2 port until l2_resp.
module l2_arbiter #(
   parameter int s_line = 256,
   parameter int s_addr = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [s_addr-1:0] i_address,
   output logic              i_resp,
   output logic [s_line-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [s_addr-1:0] d_address,
   input  logic [s_line-1:0] d_wdata,
   output logic              d_resp,
   output logic [s_line-1:0] d_rdata,
   output logic              l2_read,
   output logic              l2_write,
   output logic [s_addr-1:0] l2_address,
   output logic [s_line-1:0] l2_wdata,
   input  logic              l2_resp,
   input  logic [s_line-1:0] l2_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic [s_addr-1:0] addr_q, addr_d;
   logic [s_line-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;

   logic i_pend, d_pend, d_win;

   assign i_pend = i_read;
   assign d_pend = d_read | d_write;
   // on a tie the requester opposite the last grant wins
   assign d_win  = d_pend & (~i_pend | ~last_d_q);

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      unique case (state_q)
         IDLE: begin
            if (i_pend | d_pend) begin
               if (d_win) begin
                  state_d  = GRANT_D;
                  last_d_d = 1'b1;
                  addr_d   = d_address;
                  wdata_d  = d_wdata;
                  rd_d     = ~d_write;
                  wr_d     = d_write;
               end else begin
                  state_d  = GRANT_I;
                  last_d_d = 1'b0;
                  addr_d   = i_address;
                  wdata_d  = '0;
                  rd_d     = 1'b1;
                  wr_d     = 1'b0;
               end
            end
         end
         GRANT_I, GRANT_D: begin
            if (l2_resp) begin
               state_d = DONE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   assign l2_read    = rd_q;
   assign l2_write   = wr_q;
   assign l2_address = addr_q;
   assign l2_wdata   = wdata_q;

   assign i_resp  = (state_q == GRANT_I) & l2_resp;
   assign d_resp  = (state_q == GRANT_D) & l2_resp;
   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read;
   logic [31:0]  i_address;
   logic         i_resp;
   logic [255:0] i_rdata;
   logic         d_read;
   logic         d_write;
   logic [31:0]  d_address;
   logic [255:0] d_wdata;
   logic         d_resp;
   logic [255:0] d_rdata;
   logic         l2_read;
   logic         l2_write;
   logic [31:0]  l2_address;
   logic [255:0] l2_wdata;
   logic         l2_resp;
   logic [255:0] l2_rdata;

   l2_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address),
      .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write),
      .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .l2_read(l2_read), .l2_write(l2_write),
      .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_resp(l2_resp), .l2_rdata(l2_rdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model: owner 0 = none, 1 = I, 2 = D; cool = one-cycle cool-down
   int           m_owner;
   bit           m_cool;
   bit           m_last_d;
   logic [31:0]  m_addr;
   logic [255:0] m_wdata;
   bit           m_wr;

   logic [255:0] all_a;
   logic [255:0] all_5;
   logic [3:0]   order;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("l2_read", l2_read, m_owner != 0 && !m_wr);
      chk("l2_write", l2_write, m_owner != 0 && m_wr);
      chk("i_resp", i_resp, m_owner == 1 && l2_resp);
      chk("d_resp", d_resp, m_owner == 2 && l2_resp);
      chk("i_rdata", i_rdata, l2_rdata);
      chk("d_rdata", d_rdata, l2_rdata);
      if (m_owner != 0)
         chk("l2_address", l2_address, m_addr);
      if (m_owner == 2 && m_wr)
         chk("l2_wdata", l2_wdata, m_wdata);
   endtask

   task automatic adv();
      bit ip, dp, dwin;
      ip = i_read;
      dp = d_read | d_write;
      if (!rst) begin
         m_owner = 0; m_cool = 0; m_last_d = 0;
         m_addr = '0; m_wdata = '0; m_wr = 0;
      end else if (m_owner != 0) begin
         if (l2_resp) begin
            m_owner = 0;
            m_cool  = 1;
         end
      end else if (m_cool) begin
         m_cool = 0;
      end else if (ip || dp) begin
         dwin = dp && (!ip || !m_last_d);
         if (dwin) begin
            m_owner = 2; m_last_d = 1;
            m_addr = d_address; m_wdata = d_wdata; m_wr = d_write;
         end else begin
            m_owner = 1; m_last_d = 0;
            m_addr = i_address; m_wdata = '0; m_wr = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      tick();
      adv();
   endtask

   task automatic idle_inputs();
      i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      step();
      rst = 1;
   endtask

   initial begin
      all_a = {64{4'hA}};
      all_5 = {64{4'h5}};
      order = '0;
      rst = 0; idle_inputs();
      i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
      m_owner = 0; m_cool = 0; m_last_d = 0;
      m_addr = '0; m_wdata = '0; m_wr = 0;
      @(posedge clk); #1;

      // reset held with a pending I request
      i_read = 1; i_address = 32'h0000_1040;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("rst_l2_read", l2_read, 1'b0);
         chk("rst_i_resp", i_resp, 1'b0);
         adv();
      end
      rst = 1;
      step();
      tick();
      chk("i_grant_read", l2_read, 1'b1);
      chk("i_grant_addr", l2_address, 32'h0000_1040);
      adv();
      for (int k = 0; k < 3; k++) step();
      l2_resp = 1; l2_rdata = all_a;
      tick();
      chk("i_resp_pulse", i_resp, 1'b1);
      chk("i_rdata_val", i_rdata, all_a);
      chk("i_d_resp_low", d_resp, 1'b0);
      adv();
      idle_inputs();
      tick();
      chk("i_resp_gone", i_resp, 1'b0);
      chk("done_no_read", l2_read, 1'b0);
      adv();
      step();

      // stray l2_resp while idle is ignored
      l2_resp = 1;
      tick();
      chk("stray_i_resp", i_resp, 1'b0);
      chk("stray_d_resp", d_resp, 1'b0);
      adv();
      l2_resp = 0;

      // simultaneous after reset: D wins the first tie
      do_reset();
      i_read = 1; i_address = 32'h0000_1080;
      d_write = 1; d_address = 32'h0000_2000; d_wdata = all_5;
      step();
      tick();
      chk("tie_d_write", l2_write, 1'b1);
      chk("tie_d_addr", l2_address, 32'h0000_2000);
      chk("tie_d_wdata", l2_wdata, all_5);
      adv();
      l2_resp = 1;
      tick();
      chk("tie_d_resp", d_resp, 1'b1);
      adv();
      l2_resp = 0; d_write = 0;
      tick();
      chk("tie_done", l2_read | l2_write, 1'b0);
      adv();
      step();
      tick();
      chk("tie_i_read", l2_read, 1'b1);
      chk("tie_i_addr", l2_address, 32'h0000_1080);
      adv();
      l2_resp = 1;
      step();
      idle_inputs();
      step();

      // round-robin with both requests held
      do_reset();
      i_read = 1; d_read = 1;
      i_address = 32'h0000_0100; d_address = 32'h0000_0200;
      for (int t = 0; t < 4; t++) begin
         step();
         l2_resp = 1;
         tick();
         order = {order[2:0], d_resp};
         adv();
         l2_resp = 0;
         step();
      end
      chk("rr_order", order, 4'b1010);
      idle_inputs();
      step();

      // latched address holds while the input moves
      do_reset();
      d_read = 1; d_address = 32'h0000_3000;
      step();
      step();
      d_address = 32'h0000_4000;
      tick();
      chk("latch_addr", l2_address, 32'h0000_3000);
      adv();
      l2_resp = 1;
      tick();
      chk("latch_addr_resp", l2_address, 32'h0000_3000);
      chk("latch_d_resp", d_resp, 1'b1);
      adv();
      idle_inputs();
      step();
      step();

      // reset in the middle of an I transaction
      do_reset();
      i_read = 1; i_address = 32'h0000_5000;
      step();
      step();
      rst = 0;
      step();
      rst = 1; i_read = 0;
      tick();
      chk("midrst_read", l2_read, 1'b0);
      chk("midrst_i_resp", i_resp, 1'b0);
      adv();
      i_read = 1; i_address = 32'h0000_6000;
      step();
      tick();
      chk("post_rst_read", l2_read, 1'b1);
      chk("post_rst_addr", l2_address, 32'h0000_6000);
      adv();
      l2_resp = 1; l2_rdata = all_5;
      tick();
      chk("post_rst_resp", i_resp, 1'b1);
      adv();
      idle_inputs();
      step();
      step();

      // random traffic against the model
      for (int k = 0; k < 600; k++) begin
         rst       = ($urandom_range(0, 59) != 0);
         i_read    = $urandom_range(0, 1);
         d_read    = $urandom_range(0, 1);
         d_write   = ($urandom_range(0, 2) == 0);
         i_address = $urandom;
         d_address = $urandom;
         d_wdata   = {8{$urandom}};
         l2_resp   = ($urandom_range(0, 3) == 0);
         l2_rdata  = {8{$urandom}};
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-port arbiter that shares the single CPU-side port of the L2 cache between the L1 instruction cache and the L1 data cache.
- Latches the winning request and drives it to the L2 until the L2 responds. Routes the response back to the requester that won.
- Uses round-robin fairness so that neither L1 starves the other.
- All transfers are 256-bit lines with 32-bit addresses.

Parameters:
- s_line, 256, line width in bits for wdata and rdata on every port.
- s_addr, 32, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- i_read  in  1  I-cache line read request.
- i_address  in  s_addr  I-cache line address.
- i_resp  out  1  I-cache response, one-cycle pulse.
- i_rdata  out  s_line  I-cache read data.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line write (writeback) request.
- d_address  in  s_addr  D-cache line address.
- d_wdata  in  s_line  D-cache write data.
- d_resp  out  1  D-cache response, one-cycle pulse.
- d_rdata  out  s_line  D-cache read data.
- l2_read  out  1  read request to the L2 (L2 mem_read).
- l2_write  out  1  write request to the L2 (L2 mem_write).
- l2_address  out  s_addr  L2 address.
- l2_wdata  out  s_line  L2 write data.
- l2_resp  in  1  L2 response.
- l2_rdata  in  s_line  L2 read data.

Behaviour:
- State machine states:
  - IDLE
  - GRANT_I
  - GRANT_D
  - DONE: one-cycle cool-down that lets the served requester drop its request.
- Request visibility:
  - An I request is pending when i_read=1.
  - A D request is pending when d_read or d_write is 1.
  - d_read=1 together with d_write=1 is treated as a write.
- In IDLE with at least one request pending:
  - The arbiter picks the winner.
  - On the same edge it latches the winner's address, wdata and operation (read or write) into internal registers.
  - It moves to GRANT_I or GRANT_D.
- Winner selection:
  - If only one requester is pending, it wins.
  - If both are pending, the winner is the requester opposite the last_grant bit.
  - last_grant resets to I, so D wins the first tie.
  - last_grant is updated on every grant.
- In GRANT_x:
  - l2_read or l2_write is driven from the latched operation, l2_address from the latched address, l2_wdata from the latched wdata.
  - These stay stable until l2_resp; changes on the requester inputs are ignored.
  - Latency: the request is sampled at edge N, and l2_read/l2_write is high during cycle N+1.
- On l2_resp=1 in GRANT_x:
  - x_resp=1 is driven combinationally in the same cycle. The other requester's resp stays 0.
  - On that edge the arbiter drops l2_read/l2_write and goes to DONE.
- DONE lasts one cycle with no L2 request, then the arbiter returns to IDLE.
  - The requester deasserts its request in the cycle after resp, so DONE prevents a stale re-grant.
  - The other requester's pending request is granted from IDLE the cycle after DONE.
- Read data: i_rdata and d_rdata are both driven with l2_rdata at all times. Only the resp pulse qualifies the data.
- l2_resp arriving in IDLE or DONE is ignored; no resp is forwarded.
- Outputs in IDLE and DONE: l2_read=0, l2_write=0, i_resp=0, d_resp=0.
  - l2_address and l2_wdata hold the last latched values, which are don't-care.
- Reset (rst=0 at an edge), including mid-transaction:
  - Next state is IDLE.
  - last_grant becomes I.
  - The address/wdata/operation latches are cleared to 0.
  - From the following cycle, l2_read=0, l2_write=0, i_resp=0, d_resp=0.
  - Any in-flight transaction is abandoned without a resp.
- Throughput: at most one transaction is outstanding. Back-to-back transactions to the same requester are separated by at least 2 idle cycles (DONE, then IDLE).

Test Plan:
- Reset: hold rst=0 for 2 cycles with i_read=1 -> l2_read=0, l2_write=0, i_resp=0, d_resp=0 throughout; after release, GRANT_I is entered on the first edge.
- Single I read: i_read=1, i_address=0x0000_1040; L2 responds 5 cycles later with l2_rdata=0xAA..AA -> l2_read is high in cycle +1 with l2_address=0x1040; i_resp is pulsed for 1 cycle with i_rdata=0xAA..AA; d_resp stays 0.
- Simultaneous after reset: i_read=1 and d_write=1 with d_address=0x2000, d_wdata=0x55..55 -> D is served first (l2_write=1, l2_address=0x2000); then DONE, then IDLE; then I is granted and l2_read=1.
- Round-robin: both requesters hold requests continuously for 4 transactions -> grant order D, I, D, I.
- Latch stability: during GRANT_D, change d_address from 0x3000 to 0x4000 before l2_resp -> l2_address stays 0x3000 until resp.
- Reset mid-transaction: in GRANT_I, pulse rst=0 for one cycle -> l2_read=0 on the next cycle; i_resp is never asserted; a subsequent fresh i_read is served normally.
